// File: rtl/error_pulse_scheduler.sv
// error_pulse_scheduler: round-robin up/down pulse sequencer driving level-then-gate pairs
// and tracking a saturating signed error count.
module error_pulse_scheduler #(
    parameter int NREQ    = 2,
    parameter int PEND_W  = 6,
    parameter int ERR_W   = 10,
    parameter int ERR_MAX = 384
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    enable,
    input  logic                    zero,
    input  logic [NREQ-1:0]         req_up,
    input  logic [NREQ-1:0]         req_dn,
    output logic [NREQ-1:0]         pend_full,
    output logic [NREQ-1:0]         drop,
    output logic                    uplvl,
    output logic                    dnlvl,
    output logic                    pgp,
    output logic                    pgm,
    output logic                    busy,
    output logic signed [ERR_W-1:0] err_count,
    output logic                    sat
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int W  = PEND_W + 2;
    localparam logic signed [W-1:0]      LIMX = W'(2 ** (PEND_W - 1) - 1);
    localparam logic signed [PEND_W-1:0] LIMP = PEND_W'(2 ** (PEND_W - 1) - 1);
    localparam logic signed [W-1:0]      ONE  = W'(1);
    localparam logic signed [ERR_W-1:0]  EMAX = ERR_W'(ERR_MAX);
    localparam logic signed [ERR_W-1:0]  EONE = ERR_W'(1);

    typedef enum logic [1:0] {IDLE, LEVEL, GATE} state_t;

    state_t                   state;
    logic signed [PEND_W-1:0] pend [NREQ];
    logic signed [W-1:0]      nxt [NREQ];
    logic [NREQ-1:0]          clip;
    logic [PW-1:0]            ptr, gnt, pick;
    logic                     dir, any, suppress, done;
    int                       j;

    assign busy     = state != IDLE;
    assign suppress = dir ? err_count == EMAX : err_count == -EMAX;
    assign done     = state == GATE && enable;

    // Scan from farthest to nearest so the last hit is the first nonzero after ptr.
    always_comb begin
        any  = 1'b0;
        pick = ptr;
        j    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = int'(ptr) + k;
            j = j >= NREQ ? j - NREQ : j;
            if (pend[PW'(j)] != '0) begin
                any  = 1'b1;
                pick = PW'(j);
            end
        end
    end

    // Net per-cycle pending update; results beyond the limit are clamped and flagged.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            nxt[i] = W'(pend[i]) + W'({1'b0, req_up[i]}) - W'({1'b0, req_dn[i]})
                   - ((done && gnt == PW'(i)) ? (dir ? ONE : -ONE) : '0);
            clip[i] = nxt[i] > LIMX || nxt[i] < -LIMX;
            pend_full[i] = pend[i] == LIMP || pend[i] == -LIMP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || zero) begin
            for (int i = 0; i < NREQ; i++) pend[i] <= '0;
            drop      <= '0;
            err_count <= '0;
            sat       <= 1'b0;
            state     <= IDLE;
            {uplvl, dnlvl, pgp, pgm} <= '0;
            if (rst) begin
                ptr <= PW'(NREQ - 1);
                gnt <= '0;
                dir <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++)
                pend[i] <= clip[i] ? (nxt[i][W-1] ? -LIMP : LIMP) : nxt[i][PEND_W-1:0];
            drop <= drop | clip;
            case (state)
                IDLE: if (tick && enable && any) begin
                    state <= LEVEL;
                    gnt   <= pick;
                    ptr   <= pick;
                    dir   <= !pend[pick][PEND_W-1];
                    uplvl <= !pend[pick][PEND_W-1];
                    dnlvl <= pend[pick][PEND_W-1];
                end
                LEVEL: if (enable) begin
                    state <= GATE;
                    pgp   <= dir && !suppress;
                    pgm   <= !dir && !suppress;
                    sat   <= sat | suppress;
                end else begin
                    state <= IDLE;
                    uplvl <= 1'b0;
                    dnlvl <= 1'b0;
                end
                GATE: begin
                    state <= IDLE;
                    {uplvl, dnlvl, pgp, pgm} <= '0;
                    if (enable && !suppress) err_count <= err_count + (dir ? EONE : -EONE);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
